tiled_fetch_ctrl: RTL and testbench
===================================

Name: tiled_fetch_ctrl

Overview:
- Parametrised successor to the FFN weight/bias/input fetch controller.
- Walks a row-major matrix stored in a dual-port BRAM one tile at a time.
- Two tiling modes: row-band and column-stripe. Supports ping-pong bank selection, stall, configurable BRAM read latency, and routing of each fetched word to one of NUM_BUFFERS destination buffers.
- Sits between the BRAM read port B and the on-chip compute buffers.

Parameters:
- ADDR_WIDTH, 16, BRAM word-address width.
- DATA_WIDTH, 256, BRAM word width.
- NUM_BITS, 8, element width. WORDS_PER_ROW = ORIGINAL_COLUMNS*NUM_BITS/DATA_WIDTH (default 24).
- ORIGINAL_ROWS, 512, matrix rows.
- ORIGINAL_COLUMNS, 768, matrix columns (elements).
- TILE_ROWS, 32, rows per tile in row-band mode.
- TILE_COL_WORDS, 4, words per row in column-stripe mode.
- NUM_BUFFERS, 4, number of destination buffers.
- READ_LATENCY, 1, BRAM read latency in cycles (1 or 2).
- BANK_OFFSET, 12288, word offset of bank 1 for double buffering.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start_fetch, in, 1, one-cycle pulse requesting one tile fetch.
- reset_addr_counter, in, 1, clears tile index and ping-pong bit.
- tiles_control, in, 1, tiling mode: 1 = row-band, 0 = column-stripe.
- double_buffering, in, 1, enables bank ping-pong.
- buffer_select, in, log2(NUM_BUFFERS), destination buffer for the fetch.
- stall, in, 1, freezes address issue.
- bram_doutb, in, DATA_WIDTH, BRAM port-B read data.
- enb, out, 1, BRAM port-B enable.
- addrb, out, ADDR_WIDTH, BRAM port-B address.
- fetch_data, out, DATA_WIDTH, fetched word.
- fetch_valid, out, 1, fetch_data is valid.
- buf_we, out, NUM_BUFFERS, one-hot destination write enable; equals fetch_valid routed by the latched select.
- tile_last, out, 1, marks the last word of the tile.
- busy, out, 1, fetch in progress.
- fetch_done, out, 1, one-cycle pulse when the fetch completes.
- all_tiles_done, out, 1, sticky flag: last tile of the current mode has been fetched.

Behaviour:
- Reset: all outputs are 0. The FSM enters IDLE; tile_idx = 0, pp = 0, counters = 0.
- FSM states:
  - IDLE -> FETCH on start_fetch. At the start cycle, latch tiles_control, double_buffering and buffer_select.
  - FETCH: issue one address per non-stalled cycle. After the last address, go to DRAIN.
  - DRAIN: wait READ_LATENCY cycles for in-flight data, then go to DONE.
  - DONE: pulse fetch_done for one cycle, advance tile_idx, toggle pp if double buffering was latched, then return to IDLE.
- busy = 1 in FETCH, DRAIN and DONE.
- Address generation: addrb = bank*BANK_OFFSET + row*WORDS_PER_ROW + col, where bank = pp when double buffering is latched, else 0.
  - Row-band mode: rows tile_idx*TILE_ROWS .. +TILE_ROWS-1, col 0..WORDS_PER_ROW-1, col innermost. N = 768 words; 16 tiles.
  - Column-stripe mode: rows 0..ORIGINAL_ROWS-1, cols tile_idx*TILE_COL_WORDS .. +TILE_COL_WORDS-1. N = 2048 words; 6 tiles.
- enb = 1 only in FETCH when stall = 0. While stalled, counters freeze; words already in flight still emerge.
- fetch_valid is enb delayed by READ_LATENCY; fetch_data = bram_doutb. tile_last accompanies the word for the final address.
- Latency with no stall: start sampled at T; first addrb at T+1; first fetch_valid at T+1+READ_LATENCY; fetch_done at T+1+N+READ_LATENCY.
- Boundaries and simultaneous events:
  - After the last tile, tile_idx wraps to 0 and all_tiles_done is set. It clears on reset_addr_counter or on the next start_fetch.
  - start_fetch while busy is ignored.
  - reset_addr_counter is honoured only in IDLE. If it arrives together with start_fetch, the reset applies first and the fetch runs tile 0 in bank 0.
  - Changing tiles_control or buffer_select mid-fetch has no effect until the next start.
  - A mode change does not reset tile_idx; software pulses reset_addr_counter.
  - rst mid-fetch aborts immediately: no fetch_done and no further valid words.

Optional Feature:
- Macro FETCH_CHECKSUM_EN.
- Defined: adds output fetch_checksum[31:0]. It is the XOR of all DATA_WIDTH/32 slices of every valid word in the fetch, cleared at start and stable from fetch_done until the next start.
- Undefined: no port and no logic.

Decomposition:
- Package tiled_fetch_pkg holds:
  - WORDS_PER_ROW, tiles-per-mode and words-per-tile constants;
  - the FSM state enum (IDLE, FETCH, DRAIN, DONE);
  - the tiling-mode encoding.
- One sub-module, tiled_addr_gen: row/col/tile counters, bank offset and last-address detect. The top holds the FSM, the valid/last delay pipeline and buf_we decode.

Test Plan:
- Preload BRAM word k = k+0x1000. Row-band mode, tile 0, READ_LATENCY=1 -> 768 valid words 0x1000..0x12FF in order; tile_last on 0x12FF; fetch_done at T+770; buf_we = 4'b0001.
- Column-stripe mode after reset_addr_counter, buffer_select=2 -> first words 0x1000..0x1003, then 0x1018..0x101B; 2048 words; buf_we = 4'b0100.
- double_buffering=1, two fetches -> first fetch starts at address 0, second at 12288+768; pp toggles after each fetch_done.
- Random stall toggling during a row-band fetch -> same 768-word sequence with no gaps in data order; valid words count equals enb count; fetch_done only after the final valid word.
- Sixteen row-band fetches -> all_tiles_done set after the 16th; 17th fetch reads address 0. start_fetch asserted while busy is ignored.
- rst at word 100 mid-fetch -> all outputs 0 on the next cycle, no fetch_done. With FETCH_CHECKSUM_EN, checksum of a 0-filled tile = 0.

Source files
------------

// File: rtl/tiled_fetch_pkg.sv
// Shared constants, FSM state and tiling-mode encodings for the tiled fetch controller.
package tiled_fetch_pkg;

    localparam int unsigned WORDS_PER_ROW    = 24;
    localparam int unsigned ROW_BAND_TILES   = 16;
    localparam int unsigned COL_STRIPE_TILES = 6;
    localparam int unsigned ROW_BAND_WORDS   = 768;
    localparam int unsigned COL_STRIPE_WORDS = 2048;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } fetch_state_e;

    typedef enum logic {
        ModeColStripe = 1'b0,
        ModeRowBand   = 1'b1
    } tile_mode_e;

    function automatic int unsigned calc_words_per_row(input int unsigned cols,
                                                       input int unsigned bits,
                                                       input int unsigned data_width);
        return (cols * bits) / data_width;
    endfunction

    function automatic int unsigned calc_tiles(input int unsigned extent,
                                               input int unsigned tile_size);
        return extent / tile_size;
    endfunction

endpackage

// File: rtl/tiled_addr_gen.sv
// Tile/row/column counters, ping-pong bank bit and last-address/last-tile detection.
module tiled_addr_gen
    import tiled_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned WPR              = WORDS_PER_ROW,
    parameter int unsigned ORIGINAL_ROWS    = 512,
    parameter int unsigned TILE_ROWS        = 32,
    parameter int unsigned TILE_COL_WORDS   = 4,
    parameter int unsigned ROW_TILES        = ROW_BAND_TILES,
    parameter int unsigned COL_TILES        = COL_STRIPE_TILES,
    parameter int unsigned BANK_OFFSET      = 12288
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  step,
    input  logic                  advance,
    input  tile_mode_e            mode,
    input  logic                  bank_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_addr,
    output logic                  last_tile
);

    localparam logic [ADDR_WIDTH-1:0] ONE           = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] WPR_A         = ADDR_WIDTH'(WPR);
    localparam logic [ADDR_WIDTH-1:0] TILE_ROWS_A   = ADDR_WIDTH'(TILE_ROWS);
    localparam logic [ADDR_WIDTH-1:0] TILE_COLS_A   = ADDR_WIDTH'(TILE_COL_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BANK_A        = ADDR_WIDTH'(BANK_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] BAND_ROW_LAST = ADDR_WIDTH'(TILE_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] BAND_COL_LAST = ADDR_WIDTH'(WPR - 1);
    localparam logic [ADDR_WIDTH-1:0] STRP_ROW_LAST = ADDR_WIDTH'(ORIGINAL_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] STRP_COL_LAST = ADDR_WIDTH'(TILE_COL_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_TILE_LAST = ADDR_WIDTH'(ROW_TILES - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_TILE_LAST = ADDR_WIDTH'(COL_TILES - 1);

    logic [ADDR_WIDTH-1:0] tile_q, row_q, col_q;
    logic [ADDR_WIDTH-1:0] row_last, col_last, base_row, base_col, bank_base;
    logic                  pp_q, last_col;

    always_comb begin
        if (mode == ModeRowBand) begin
            row_last  = BAND_ROW_LAST;
            col_last  = BAND_COL_LAST;
            base_row  = tile_q * TILE_ROWS_A;
            base_col  = '0;
            last_tile = (tile_q == ROW_TILE_LAST);
        end else begin
            row_last  = STRP_ROW_LAST;
            col_last  = STRP_COL_LAST;
            base_row  = '0;
            base_col  = tile_q * TILE_COLS_A;
            last_tile = (tile_q == COL_TILE_LAST);
        end
        bank_base = (bank_en && pp_q) ? BANK_A : '0;
        addr      = bank_base + (base_row + row_q) * WPR_A + base_col + col_q;
        last_col  = (col_q == col_last);
        last_addr = last_col && (row_q == row_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_q <= '0;
            pp_q   <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            if (clear) begin
                tile_q <= '0;
                pp_q   <= 1'b0;
            end else if (advance) begin
                tile_q <= last_tile ? '0 : tile_q + ONE;
                if (bank_en) begin
                    pp_q <= ~pp_q;
                end
            end

            if (start) begin
                row_q <= '0;
                col_q <= '0;
            end else if (step) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + ONE;
                end else begin
                    col_q <= col_q + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/tiled_fetch_ctrl.sv
// Tiled BRAM fetch controller: FSM, read-latency valid/last pipeline and buffer routing.
// Define FETCH_CHECKSUM_EN to add the fetch_checksum output.
module tiled_fetch_ctrl
    import tiled_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned DATA_WIDTH       = 256,
    parameter int unsigned NUM_BITS         = 8,
    parameter int unsigned ORIGINAL_ROWS    = 512,
    parameter int unsigned ORIGINAL_COLUMNS = 768,
    parameter int unsigned TILE_ROWS        = 32,
    parameter int unsigned TILE_COL_WORDS   = 4,
    parameter int unsigned NUM_BUFFERS      = 4,
    parameter int unsigned READ_LATENCY     = 1,
    parameter int unsigned BANK_OFFSET      = 12288
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_fetch,
    input  logic                  reset_addr_counter,
    input  logic                  tiles_control,
    input  logic                  double_buffering,
    input  logic [(NUM_BUFFERS > 1 ? $clog2(NUM_BUFFERS) : 1)-1:0] buffer_select,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] bram_doutb,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    output logic [NUM_BUFFERS-1:0] buf_we,
    output logic                  tile_last,
    output logic                  busy,
    output logic                  fetch_done,
    output logic                  all_tiles_done
`ifdef FETCH_CHECKSUM_EN
    ,
    output logic [31:0]           fetch_checksum
`endif
);

    localparam int unsigned SEL_W     = NUM_BUFFERS > 1 ? $clog2(NUM_BUFFERS) : 1;
    localparam int unsigned WPR       = calc_words_per_row(ORIGINAL_COLUMNS, NUM_BITS,
                                                           DATA_WIDTH);
    localparam int unsigned ROW_TILES = calc_tiles(ORIGINAL_ROWS, TILE_ROWS);
    localparam int unsigned COL_TILES = calc_tiles(WPR, TILE_COL_WORDS);
    localparam logic [1:0]  DRAIN_END = 2'(READ_LATENCY - 1);

    fetch_state_e            state_q, state_d;
    tile_mode_e              mode_q;
    logic                    db_q;
    logic [SEL_W-1:0]        sel_q;
    logic [1:0]              drain_cnt_q;
    logic [READ_LATENCY-1:0] valid_pipe_q, last_pipe_q;
    logic                    all_done_q;
    logic                    accept, clear, last_addr, last_tile;
    logic [ADDR_WIDTH-1:0]   gen_addr;

    // A start in IDLE is the only accepted start; counter clears are likewise IDLE-only.
    assign accept = (state_q == StIdle) && start_fetch;
    assign clear  = (state_q == StIdle) && reset_addr_counter;

    tiled_addr_gen #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .WPR           (WPR),
        .ORIGINAL_ROWS (ORIGINAL_ROWS),
        .TILE_ROWS     (TILE_ROWS),
        .TILE_COL_WORDS(TILE_COL_WORDS),
        .ROW_TILES     (ROW_TILES),
        .COL_TILES     (COL_TILES),
        .BANK_OFFSET   (BANK_OFFSET)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .start    (accept),
        .step     (enb),
        .advance  (state_q == StDone),
        .mode     (mode_q),
        .bank_en  (db_q),
        .addr     (gen_addr),
        .last_addr(last_addr),
        .last_tile(last_tile)
    );

    always_comb begin
        state_d    = state_q;
        enb        = 1'b0;
        fetch_done = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start_fetch) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                enb = !stall;
                if (enb && last_addr) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_cnt_q == DRAIN_END) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                fetch_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mode_q       <= ModeColStripe;
            db_q         <= 1'b0;
            sel_q        <= '0;
            drain_cnt_q  <= '0;
            valid_pipe_q <= '0;
            last_pipe_q  <= '0;
            all_done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q <= tile_mode_e'(tiles_control);
                db_q   <= double_buffering;
                sel_q  <= buffer_select;
            end
            drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 2'd1 : 2'd0;

            valid_pipe_q[0] <= enb;
            last_pipe_q[0]  <= enb && last_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_pipe_q[i] <= valid_pipe_q[i-1];
                last_pipe_q[i]  <= last_pipe_q[i-1];
            end

            if (clear || accept) begin
                all_done_q <= 1'b0;
            end else if (state_q == StDone && last_tile) begin
                all_done_q <= 1'b1;
            end
        end
    end

    assign fetch_valid    = valid_pipe_q[READ_LATENCY-1];
    assign tile_last      = last_pipe_q[READ_LATENCY-1];
    assign fetch_data     = fetch_valid ? bram_doutb : '0;
    assign addrb          = enb ? gen_addr : '0;
    assign all_tiles_done = all_done_q;

    always_comb begin
        buf_we = '0;
        if (fetch_valid) begin
            buf_we[sel_q] = 1'b1;
        end
    end

`ifdef FETCH_CHECKSUM_EN
    logic [31:0] csum_q, word_fold;

    always_comb begin
        word_fold = '0;
        for (int i = 0; i < DATA_WIDTH / 32; i++) begin
            word_fold = word_fold ^ bram_doutb[i*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            csum_q <= '0;
        end else if (fetch_valid) begin
            csum_q <= csum_q ^ word_fold;
        end
    end

    assign fetch_checksum = csum_q;
`endif

endmodule

// File: tb/tb_tiled_fetch_ctrl.sv
// Directed bench for tiled_fetch_ctrl: table of fetch scenarios plus reset/wrap sequences.
module tb_tiled_fetch_ctrl;

    localparam int DW = 256;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_fetch = 1'b0;
    logic          reset_addr_counter = 1'b0;
    logic          tiles_control = 1'b0;
    logic          double_buffering = 1'b0;
    logic [1:0]    buffer_select = '0;
    logic          stall = 1'b0;
    logic [DW-1:0] bram_doutb = '0;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;
    logic [3:0]    buf_we;
    logic          tile_last;
    logic          busy;
    logic          fetch_done;
    logic          all_tiles_done;
`ifdef FETCH_CHECKSUM_EN
    logic [31:0]   fetch_checksum;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit zero_fill = 1'b0;

    tiled_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .start_fetch       (start_fetch),
        .reset_addr_counter(reset_addr_counter),
        .tiles_control     (tiles_control),
        .double_buffering  (double_buffering),
        .buffer_select     (buffer_select),
        .stall             (stall),
        .bram_doutb        (bram_doutb),
        .enb               (enb),
        .addrb             (addrb),
        .fetch_data        (fetch_data),
        .fetch_valid       (fetch_valid),
        .buf_we            (buf_we),
        .tile_last         (tile_last),
        .busy              (busy),
        .fetch_done        (fetch_done),
        .all_tiles_done    (all_tiles_done)
`ifdef FETCH_CHECKSUM_EN
        ,
        .fetch_checksum    (fetch_checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle BRAM: word k holds k + 0x1000.
    always @(posedge clk) begin
        if (enb) bram_doutb <= zero_fill ? '0 : DW'(addrb) + DW'(32'h1000);
    end

    typedef struct {
        bit         rc;
        bit         mode;
        bit         db;
        logic [1:0] sel;
        bit         stl;
        bit         poke;
        int         tile;
        int         bank;
        int         n;
        int         first_addr;
        int         last_addr;
        logic [3:0] we;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_addr(input bit mode, input int tile, input int bank, input int k);
        if (mode) return bank * 12288 + tile * 768 + k;
        return bank * 12288 + (k / 4) * 24 + tile * 4 + (k % 4);
    endfunction

    task automatic run_fetch(input vec_t v, input string tag);
        int c0, nvalid, nenb, nlast, last_pos, done_cyc, last_valid_cyc, seq_err, we_err;
        int first_a;
        logic [DW-1:0] first_d, last_d, exp_d;
        nvalid = 0; nenb = 0; nlast = 0; last_pos = -1; done_cyc = -1;
        last_valid_cyc = -1; seq_err = 0; we_err = 0; first_a = -1;
        first_d = '0; last_d = '0;
        @(negedge clk);
        start_fetch        = 1'b1;
        reset_addr_counter = v.rc;
        tiles_control      = v.mode;
        double_buffering   = v.db;
        buffer_select      = v.sel;
        c0 = cyc;
        for (int t = 1; t <= 6000 && done_cyc < 0; t++) begin
            @(negedge clk);
            if (fetch_valid) begin
                exp_d = DW'(model_addr(v.mode, v.tile, v.bank, nvalid) + 32'h1000);
                if (fetch_data !== exp_d) seq_err++;
                if (buf_we !== v.we) we_err++;
                if (tile_last) begin
                    nlast++;
                    last_pos = nvalid;
                end
                if (nvalid == 0) first_d = fetch_data;
                last_d = fetch_data;
                last_valid_cyc = cyc;
                nvalid++;
            end else if (buf_we !== 4'b0) begin
                we_err++;
            end
            if (enb) begin
                if (nenb == 0) first_a = int'(addrb);
                nenb++;
            end
            if (fetch_done) done_cyc = cyc;
            start_fetch        = 1'b0;
            reset_addr_counter = 1'b0;
            stall = v.stl ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (v.poke && t == 20) begin
                start_fetch        = 1'b1;
                reset_addr_counter = 1'b1;
                tiles_control      = ~v.mode;
                double_buffering   = ~v.db;
                buffer_select      = v.sel + 2'd1;
            end
        end
        stall = 1'b0;
        check({tag, "_done_seen"}, DW'(done_cyc >= 0), DW'(1));
        check({tag, "_valid_count"}, DW'(nvalid), DW'(v.n));
        check({tag, "_enb_count"}, DW'(nenb), DW'(v.n));
        check({tag, "_first_addr"}, DW'(first_a), DW'(v.first_addr));
        check({tag, "_first_data"}, first_d, DW'(v.first_addr + 32'h1000));
        check({tag, "_last_data"}, last_d, DW'(v.last_addr + 32'h1000));
        check({tag, "_seq_errors"}, DW'(seq_err), DW'(0));
        check({tag, "_buf_we_errors"}, DW'(we_err), DW'(0));
        check({tag, "_tile_last_pos"}, DW'({nlast, last_pos}), DW'({32'd1, v.n - 1}));
        if (v.stl) check({tag, "_done_after_last"}, DW'(done_cyc - last_valid_cyc), DW'(1));
        else       check({tag, "_done_latency"}, DW'(done_cyc - c0), DW'(v.n + 2));
        @(negedge clk);
        check({tag, "_idle_after"}, DW'({busy, fetch_valid}), DW'(0));
    endtask

    vec_t vecs[6];
    vec_t w;
    int   nv, nd;

    initial begin
        //           rc mode db sel stl poke tile bank n     first  last   we
        vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 768,  0,     767,   4'b0001};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 0, 0, 2048, 0,     12267, 4'b0100};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1, 0, 2048, 4,     12271, 4'b0100};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 0, 0, 768,  0,     767,   4'b0010};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1, 1, 768,  13056, 13823, 4'b1000};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 2, 0, 768,  1536,  2303,  4'b0001};

        repeat (3) @(negedge clk);
        check("reset_ctrl", DW'({enb, fetch_valid, buf_we, tile_last, busy, fetch_done,
                                 all_tiles_done}), DW'(0));
        check("reset_addrb", DW'(addrb), DW'(0));
        check("reset_data", fetch_data, DW'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_fetch(vecs[i], $sformatf("v%0d", i));

        // Walk all sixteen row-band tiles, then confirm the wrap to tile 0.
        for (int i = 0; i < 17; i++) begin
            w = '{(i == 0), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, i % 16, 0, 768,
                  (i % 16) * 768, (i % 16) * 768 + 767, 4'b0001};
            run_fetch(w, $sformatf("wrap%0d", i));
            check($sformatf("wrap%0d_all_done", i), DW'(all_tiles_done), DW'(i == 15));
        end

        // Synchronous reset in the middle of a fetch.
        @(negedge clk);
        start_fetch = 1'b1; reset_addr_counter = 1'b1; tiles_control = 1'b1;
        double_buffering = 1'b0; buffer_select = 2'd0;
        nv = 0;
        for (int t = 0; t < 2000 && nv < 100; t++) begin
            @(negedge clk);
            start_fetch = 1'b0; reset_addr_counter = 1'b0;
            if (fetch_valid) nv++;
        end
        check("rst_reached_word100", DW'(nv), DW'(100));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", DW'({enb, fetch_valid, buf_we, tile_last, busy, fetch_done,
                                   all_tiles_done}), DW'(0));
        check("rst_mid_addrb", DW'(addrb), DW'(0));
        check("rst_mid_data", fetch_data, DW'(0));
        rst = 1'b0;
        nv = 0; nd = 0;
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            if (fetch_valid) nv++;
            if (fetch_done) nd++;
        end
        check("rst_no_more_words", DW'(nv), DW'(0));
        check("rst_no_done", DW'(nd), DW'(0));

`ifdef FETCH_CHECKSUM_EN
        zero_fill = 1'b1;
        @(negedge clk);
        start_fetch = 1'b1; reset_addr_counter = 1'b1; tiles_control = 1'b1;
        nd = 0;
        for (int t = 0; t < 2000 && nd == 0; t++) begin
            @(negedge clk);
            start_fetch = 1'b0; reset_addr_counter = 1'b0;
            if (fetch_done) begin
                nd = 1;
                check("csum_zero_tile", DW'(fetch_checksum), DW'(0));
            end
        end
        check("csum_done_seen", DW'(nd), DW'(1));
        zero_fill = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
